// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer and ROM port arbiter.
// Owns the fetch PC, shares the single-port instruction ROM with a debug
// read port, and delivers fetched words to decode through a 2-entry queue.
// ROM read data returns one cycle after the address is presented.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata
);

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DEBUG = 1'b1
    } grant_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    // Fetch PC and arbitration history
    logic [31:0] pc;
    grant_e      last_grant;

    // Tag describing the ROM read whose data arrives this cycle
    logic        tag_valid;
    grant_e      tag_kind;
    logic [31:0] tag_pc;

    // Shift-style queue: slot0 is the head and drives the decode outputs
    entry_t      slot0;
    entry_t      slot1;
    logic        valid0;
    logic        valid1;

    // Last debug read word, held between debug responses
    logic [31:0] dbg_rdata_q;

    // Per-cycle decisions
    logic        pop;
    logic        push;
    logic        inflight_fetch;
    logic [1:0]  occupancy;
    logic        fetch_ok;
    logic        grant_dbg;
    logic        grant_fetch;
    logic [31:0] issue_addr;
    entry_t      push_entry;

    // Byte-offset bits are always forced to zero on the ROM address
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{issue_addr[1:0], redirect_pc[1:0]};

    // Arbitration, credit check and queue push/pop decisions
    always_comb begin
        // NOTE: every signal of this block is assigned on every pass, so no latch can form.
        pop            = valid0 && inst_ready;
        inflight_fetch = tag_valid && (tag_kind == GRANT_FETCH);
        // A redirect makes the fetch returning this cycle stale: its word is dropped.
        push           = inflight_fetch && !redirect_valid;
        // An entry popped this cycle is gone before the fetch issued now can land,
        // so its slot counts as free; this is what sustains one word per cycle.
        occupancy      = {1'b0, valid0} + {1'b0, valid1} - {1'b0, pop};
        fetch_ok       = !redirect_valid && ((occupancy + {1'b0, inflight_fetch}) < 2'd2);
        // No ROM issue is made while reset is held.
        grant_dbg      = reset && dbg_req && (!fetch_ok || (last_grant == GRANT_FETCH));
        grant_fetch    = reset && fetch_ok && !grant_dbg;
        issue_addr     = grant_dbg ? dbg_addr : pc;
        push_entry.data = rom_data;
        push_entry.pc   = tag_pc;
    end

    // ROM sees a word-aligned byte address; bits above the ROM index pass through
    assign rom_addr = {issue_addr[31:ADDR_WIDTH+2], issue_addr[ADDR_WIDTH+1:2], 2'b00};

    // PC advance/redirect, grant history and in-flight tag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            pc         <= {RESET_PC[31:2], 2'b00};
            last_grant <= GRANT_DEBUG;
            tag_valid  <= 1'b0;
            tag_kind   <= GRANT_FETCH;
            tag_pc     <= 32'h0;
        end else begin
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (grant_fetch) begin
                pc <= pc + 32'd4;
            end
            if (grant_dbg) begin
                last_grant <= GRANT_DEBUG;
            end else if (grant_fetch) begin
                last_grant <= GRANT_FETCH;
            end
            tag_valid <= grant_dbg || grant_fetch;
            tag_kind  <= grant_dbg ? GRANT_DEBUG : GRANT_FETCH;
            tag_pc    <= pc;
        end
    end

    // Two-entry instruction queue with flush on redirect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: queue storage is reset because slot0 is the inst_data/inst_pc output register.
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            slot0  <= '0;
            slot1  <= '0;
        end else if (redirect_valid) begin
            // A handshake this cycle still completes; everything else is discarded.
            valid0 <= 1'b0;
            valid1 <= 1'b0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    slot0  <= slot1;
                    valid0 <= valid1;
                    valid1 <= 1'b0;
                end
                2'b10: begin
                    if (!valid0) begin
                        slot0  <= push_entry;
                        valid0 <= 1'b1;
                    end else begin
                        slot1  <= push_entry;
                        valid1 <= 1'b1;
                    end
                end
                2'b11: begin
                    if (valid1) begin
                        slot0 <= slot1;
                        slot1 <= push_entry;
                    end else begin
                        slot0 <= push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Capture debug read data so it stays visible until the next debug response
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dbg_rdata_q <= 32'h0;
        end else if (dbg_rvalid) begin
            dbg_rdata_q <= rom_data;
        end
    end

    assign inst_valid = valid0;
    assign inst_data  = slot0.data;
    assign inst_pc    = slot0.pc;
    assign dbg_gnt    = grant_dbg;
    assign dbg_rvalid = tag_valid && (tag_kind == GRANT_DEBUG);
    assign dbg_rdata  = dbg_rvalid ? rom_data : dbg_rdata_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl with a ROM model where word[i] = i.
module tb_inst_fetch_ctrl;

    localparam int AW = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        dbg_req = 1'b0;
    logic [31:0] dbg_addr = 32'h0;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    inst_fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .dbg_req       (dbg_req),
        .dbg_addr      (dbg_addr),
        .dbg_gnt       (dbg_gnt),
        .dbg_rvalid    (dbg_rvalid),
        .dbg_rdata     (dbg_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [AW-1:0] idx;
        idx = a[AW+1:2];
        return 32'(idx);
    endfunction

    // Synchronous ROM: one-cycle read latency
    always @(posedge clock) rom_data <= rom_word(rom_addr);

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        dbg_req        = 1'b0;
        dbg_addr       = 32'h0;
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        dbg_req  = 1'b1;
        dbg_addr = 32'h40;
        inst_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        n_tests++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL rst_inst_data: got %h want 0", inst_data); end
        n_tests++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
        n_tests++; if (dbg_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_dbg_gnt: got %b want 0", dbg_gnt); end
        n_tests++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_dbg_rvalid: got %b want 0", dbg_rvalid); end
        n_tests++; if (dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_dbg_rdata: got %h want 0", dbg_rdata); end
        n_tests++; if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL rst_rom_addr: got %h want 0", rom_addr); end
    endtask

    task automatic test_stream();
        exp_t e;
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 10) exp_q.push_back(exp_t'{pc: 32'(4 * c), data: 32'(c)});
            @(negedge clock);
            n_tests++;
            if (inst_valid !== (c >= 2)) begin
                n_fail++; $display("FAIL stream_valid c=%0d: got %b want %b", c, inst_valid, (c >= 2));
            end
            if (c < 10) begin
                n_tests++;
                if (rom_addr !== 32'(4 * c)) begin
                    n_fail++; $display("FAIL stream_rom_addr c=%0d: got %h want %h", c, rom_addr, 32'(4 * c));
                end
            end
            if (inst_valid && inst_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_unexpected: pc=%h data=%h, want no handshake", inst_pc, inst_data);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_pc !== e.pc || inst_data !== e.data) begin
                        n_fail++; $display("FAIL stream_hs: got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, e.pc, e.data);
                    end
                end
            end
            next_cycle();
        end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_drain: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [31:0] want_addr;
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_t'{pc: 32'(4 * i), data: 32'(i)});
        for (int c = 0; c < 6; c++) begin
            want_addr = (c == 0) ? 32'h0 : (c == 1) ? 32'h4 : 32'h8;
            @(negedge clock);
            n_tests++;
            if (rom_addr !== want_addr) begin
                n_fail++; $display("FAIL stall_rom_addr c=%0d: got %h want %h", c, rom_addr, want_addr);
            end
            n_tests++;
            if (inst_valid !== (c >= 2) || (c >= 2 && inst_pc !== 32'h0)) begin
                n_fail++; $display("FAIL stall_head c=%0d: got valid=%b pc=%h want valid=%b pc=0", c, inst_valid, inst_pc, (c >= 2));
            end
            next_cycle();
        end
        inst_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            if (inst_valid && inst_ready) begin
                n_tests++;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst_data !== e.data) begin
                    n_fail++; $display("FAIL stall_hs: got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, e.pc, e.data);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_timeout: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        exp_t e;
        do_reset();
        inst_ready = 1'b0;
        next_cycle();
        next_cycle();
        // Cycle N: one word queued, one fetch returning
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        @(negedge clock);
        n_tests++;
        if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL redir_setup: got valid=%b want 1", inst_valid); end
        next_cycle();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        exp_q.push_back(exp_t'{pc: 32'h40, data: 32'h10});
        exp_q.push_back(exp_t'{pc: 32'h44, data: 32'h11});
        exp_q.push_back(exp_t'{pc: 32'h48, data: 32'h12});
        @(negedge clock);
        n_tests++;
        if (inst_valid !== 1'b0 || rom_addr !== 32'h40) begin
            n_fail++; $display("FAIL redir_n1: got valid=%b rom_addr=%h want valid=0 rom_addr=00000040", inst_valid, rom_addr);
        end
        next_cycle();
        @(negedge clock);
        n_tests++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_n2: got valid=%b want 0", inst_valid); end
        next_cycle();
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            if (c == 0) begin
                n_tests++;
                if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL redir_n3: got valid=%b want 1", inst_valid); end
            end
            if (inst_valid && inst_ready) begin
                n_tests++;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst_data !== e.data) begin
                    n_fail++; $display("FAIL redir_hs: got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, e.pc, e.data);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL redir_timeout: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_debug();
        exp_t e;
        int   gnt_cycle;
        gnt_cycle = -1;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 13; i++) exp_q.push_back(exp_t'{pc: 32'(4 * i), data: 32'(i)});
        for (int c = 0; c < 16; c++) begin
            if (c == 4) begin
                dbg_req  = 1'b1;
                dbg_addr = 32'h23;
            end
            @(negedge clock);
            if (dbg_gnt && gnt_cycle < 0) begin
                gnt_cycle = c;
                n_tests++;
                if (rom_addr !== 32'h20 || (c - 4) > 2) begin
                    n_fail++; $display("FAIL dbg_gnt: got rom_addr=%h wait=%0d want rom_addr=00000020 wait<=2", rom_addr, c - 4);
                end
            end
            if (gnt_cycle >= 0 && c == gnt_cycle + 1) begin
                n_tests++;
                if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h8) begin
                    n_fail++; $display("FAIL dbg_resp: got rvalid=%b rdata=%h want rvalid=1 rdata=00000008", dbg_rvalid, dbg_rdata);
                end
            end
            if (gnt_cycle >= 0 && c == gnt_cycle + 2) begin
                n_tests++;
                if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h8 || inst_valid !== 1'b0) begin
                    n_fail++; $display("FAIL dbg_after: got rvalid=%b rdata=%h inst_valid=%b want 0/00000008/0", dbg_rvalid, dbg_rdata, inst_valid);
                end
            end
            if (inst_valid && inst_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL dbg_unexpected: pc=%h data=%h, want no handshake", inst_pc, inst_data);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_pc !== e.pc || inst_data !== e.data) begin
                        n_fail++; $display("FAIL dbg_stream: got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, e.pc, e.data);
                    end
                end
            end
            next_cycle();
            if (gnt_cycle == c) dbg_req = 1'b0;
        end
        n_tests++;
        if (gnt_cycle < 0) begin n_fail++; $display("FAIL dbg_timeout: no dbg_gnt, want one within 2 cycles"); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL dbg_drain: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        exp_t e;
        do_reset();
        inst_ready = 1'b1;
        exp_q.push_back(exp_t'{pc: 32'h0, data: 32'h0});
        exp_q.push_back(exp_t'{pc: 32'h4, data: 32'h1});
        exp_q.push_back(exp_t'{pc: 32'hFFFF_FFFC, data: 32'hFF});
        exp_q.push_back(exp_t'{pc: 32'h0, data: 32'h0});
        exp_q.push_back(exp_t'{pc: 32'h4, data: 32'h1});
        exp_q.push_back(exp_t'{pc: 32'h8, data: 32'h2});
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'hFFFF_FFFC;
            end
            @(negedge clock);
            if (c == 4) begin
                n_tests++;
                if (rom_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffc", rom_addr); end
            end
            if (c == 5) begin
                n_tests++;
                if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h want 00000000", rom_addr); end
            end
            if (inst_valid && inst_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL wrap_unexpected: pc=%h data=%h, want no handshake", inst_pc, inst_data);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_pc !== e.pc || inst_data !== e.data) begin
                        n_fail++; $display("FAIL wrap_hs: got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, e.pc, e.data);
                    end
                end
            end
            next_cycle();
            redirect_valid = 1'b0;
        end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_drain: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int rvalid_seen;
        rvalid_seen = 0;
        do_reset();
        inst_ready = 1'b1;
        repeat (3) next_cycle();
        dbg_req  = 1'b1;
        dbg_addr = 32'h20;
        @(negedge clock);
        n_tests++;
        if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt0: got %b want 1", dbg_gnt); end
        next_cycle();
        dbg_req = 1'b0;
        @(negedge clock);
        n_tests++;
        if (dbg_rdata !== 32'h8) begin n_fail++; $display("FAIL mid_rdata0: got %h want 00000008", dbg_rdata); end
        next_cycle();
        dbg_req  = 1'b1;
        dbg_addr = 32'h30;
        @(negedge clock);
        n_tests++;
        if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt1: got %b want 1", dbg_gnt); end
        next_cycle();
        // Debug read to 0x30 is in flight now; reset asynchronously.
        reset   = 1'b0;
        dbg_req = 1'b0;
        #1;
        n_tests++;
        if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL mid_inst: got valid=%b data=%h pc=%h want 0/0/0", inst_valid, inst_data, inst_pc);
        end
        n_tests++;
        if (dbg_gnt !== 1'b0 || dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin
            n_fail++; $display("FAIL mid_dbg: got gnt=%b rvalid=%b rdata=%h want 0/0/0", dbg_gnt, dbg_rvalid, dbg_rdata);
        end
        n_tests++;
        if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rom_addr: got %h want 0", rom_addr); end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (dbg_rvalid) rvalid_seen++;
            next_cycle();
        end
        n_tests++;
        if (rvalid_seen != 0) begin n_fail++; $display("FAIL mid_rvalid: got %0d pulses want 0", rvalid_seen); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_debug();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
